// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths and CDB source encodings for the CDB arbiter slice.
package cdb_arbiter_pkg;
  localparam int RBID = 4;
  localparam int RLEN = 32;
  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;
endpackage

// File: rtl/cdb_queue.sv
// cdb_queue: circular FIFO holding results that lost CDB arbitration.
module cdb_queue #(
  parameter int W = 36,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [PW-1:0] hd_q, hd_d, tl_q, tl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tl_q] = wdata;
    hd_d = pop ? inc(hd_q) : hd_q;
    tl_d = push ? inc(tl_q) : tl_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hd_q <= '0;
      tl_q <= '0;
      cnt_q <= '0;
    end else begin
      hd_q <= hd_d;
      tl_q <= tl_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign head = mem_q[hd_q];
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the CDB between ALU and LSB results, with per-source overflow queues.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int RBW = RBID,
  parameter int DW = RLEN,
  parameter int QDEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           flush,
  input  logic           alu_valid,
  input  logic [RBW-1:0] alu_idx,
  input  logic [DW-1:0]  alu_val,
  output logic           alu_ready,
  input  logic           lsb_valid,
  input  logic [RBW-1:0] lsb_idx,
  input  logic [DW-1:0]  lsb_val,
  output logic           lsb_ready,
  output logic           cdb_valid,
  output logic [RBW-1:0] cdb_idx,
  output logic [DW-1:0]  cdb_val,
  output logic           cdb_src
);
  localparam int EW = RBW + DW;
  logic go, alu_acc, lsb_acc, alu_cand, lsb_cand, win_lsb, any;
  logic alu_push, alu_pop, lsb_push, lsb_pop;
  logic alu_empty, alu_full, lsb_empty, lsb_full;
  logic [EW-1:0] alu_head, lsb_head, alu_ent, lsb_ent;
  logic cdb_valid_q, cdb_valid_d, cdb_src_q, cdb_src_d, rr_last_q, rr_last_d;
  logic [EW-1:0] cdb_ent_q, cdb_ent_d;
  cdb_queue #(.W(EW), .DEPTH(QDEPTH)) u_alu_q (
    .clk(clk), .rst(rst), .clear(flush), .push(alu_push), .pop(alu_pop),
    .wdata({alu_idx, alu_val}), .head(alu_head), .empty(alu_empty), .full(alu_full)
  );
  cdb_queue #(.W(EW), .DEPTH(QDEPTH)) u_lsb_q (
    .clk(clk), .rst(rst), .clear(flush), .push(lsb_push), .pop(lsb_pop),
    .wdata({lsb_idx, lsb_val}), .head(lsb_head), .empty(lsb_empty), .full(lsb_full)
  );
  // A queued head always outranks this cycle's input so per-source order stays FIFO.
  always_comb begin
    go = rdy && !flush;
    alu_ready = go && !alu_full;
    lsb_ready = go && !lsb_full;
    alu_acc = alu_valid && alu_ready;
    lsb_acc = lsb_valid && lsb_ready;
    alu_cand = !alu_empty || alu_acc;
    lsb_cand = !lsb_empty || lsb_acc;
    alu_ent = alu_empty ? {alu_idx, alu_val} : alu_head;
    lsb_ent = lsb_empty ? {lsb_idx, lsb_val} : lsb_head;
    win_lsb = lsb_cand && (!alu_cand || rr_last_q == CDB_SRC_ALU);
    any = alu_cand || lsb_cand;
    alu_pop = go && !alu_empty && !win_lsb;
    lsb_pop = go && !lsb_empty && win_lsb;
    alu_push = alu_acc && !(alu_empty && !win_lsb);
    lsb_push = lsb_acc && !(lsb_empty && win_lsb);
    cdb_valid_d = rdy ? any : cdb_valid_q;
    cdb_ent_d = rdy && any ? (win_lsb ? lsb_ent : alu_ent) : cdb_ent_q;
    cdb_src_d = rdy && any ? win_lsb : cdb_src_q;
    rr_last_d = rdy && alu_cand && lsb_cand ? win_lsb : rr_last_q;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cdb_valid_q <= 1'b0;
      cdb_ent_q <= '0;
      cdb_src_q <= CDB_SRC_ALU;
      rr_last_q <= CDB_SRC_LSB;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_ent_q <= cdb_ent_d;
      cdb_src_q <= cdb_src_d;
      rr_last_q <= rr_last_d;
    end
  end
  assign cdb_valid = cdb_valid_q;
  assign {cdb_idx, cdb_val} = cdb_ent_q;
  assign cdb_src = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus against a queue-based model of the CDB arbiter.
module tb_cdb_arbiter;
  localparam int QD = 2;
  logic clk, rst, rdy, flush;
  logic alu_valid, alu_ready, lsb_valid, lsb_ready;
  logic [3:0] alu_idx, lsb_idx, cdb_idx;
  logic [31:0] alu_val, lsb_val, cdb_val;
  logic cdb_valid, cdb_src;
  int total = 0;
  int bad = 0;
  logic [35:0] qa[$];
  logic [35:0] ql[$];
  logic rr = 1'b1;
  logic e_v = 1'b0;
  logic e_s = 1'b0;
  logic [3:0] e_i = '0;
  logic [31:0] e_d = '0;

  cdb_arbiter #(.RBW(4), .DW(32), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_val(alu_val), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_idx(lsb_idx), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model treats each source as "oldest outstanding result first".
  task automatic cyc(input logic av, input logic [3:0] ai, input logic [31:0] ad,
                     input logic lv, input logic [3:0] li, input logic [31:0] ld,
                     input logic r = 1'b1, input logic f = 1'b0);
    logic ar, lr, pick_lsb;
    logic [35:0] e;
    alu_valid = av; alu_idx = ai; alu_val = ad;
    lsb_valid = lv; lsb_idx = li; lsb_val = ld;
    rdy = r; flush = f;
    #1;
    ar = r && !f && qa.size() < QD;
    lr = r && !f && ql.size() < QD;
    chk("alu_ready", alu_ready, ar);
    chk("lsb_ready", lsb_ready, lr);
    if (f) begin
      qa.delete(); ql.delete();
      e_v = 0; e_i = '0; e_d = '0; e_s = 0; rr = 1'b1;
    end else if (r) begin
      if (av && ar) qa.push_back({ai, ad});
      if (lv && lr) ql.push_back({li, ld});
      if (qa.size() == 0 && ql.size() == 0) e_v = 1'b0;
      else begin
        pick_lsb = ql.size() != 0 && (qa.size() == 0 || rr == 1'b0);
        if (qa.size() != 0 && ql.size() != 0) rr = pick_lsb;
        if (pick_lsb) e = ql.pop_front();
        else e = qa.pop_front();
        e_v = 1'b1; {e_i, e_d} = e; e_s = pick_lsb;
      end
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", cdb_valid, e_v);
    if (e_v || f) begin
      chk("cdb_idx", cdb_idx, e_i);
      chk("cdb_val", cdb_val, e_d);
      chk("cdb_src", cdb_src, e_s);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    alu_valid = 0; alu_idx = '0; alu_val = '0;
    lsb_valid = 0; lsb_idx = '0; lsb_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_idx", cdb_idx, 4'd0);
    chk("rst_val", cdb_val, 32'd0);
    chk("rst_src", cdb_src, 1'b0);
    rst = 1'b0;
    // Single ALU result, then an idle cycle.
    cyc(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0);
    idle(2);
    // Tie after reset goes to the ALU; following tie goes to the LSB.
    cyc(1'b1, 4'd1, 32'ha1, 1'b1, 4'd2, 32'hb2);
    cyc(1'b1, 4'd4, 32'ha4, 1'b1, 4'd5, 32'hb5);
    idle(4);
    // Continuous ALU stream with the LSB offering every cycle.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 4'(i), $urandom, 1'b1, 4'(8 + i), $urandom);
    idle(5);
    // Fill both queues, then flush with a valid ALU input.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 4'(i), $urandom, 1'b1, 4'(12 + i), $urandom);
    cyc(1'b1, 4'd7, 32'hdead, 1'b1, 4'd9, 32'hbeef, 1'b1, 1'b1);
    idle(1);
    cyc(1'b1, 4'd6, 32'h66, 1'b1, 4'd10, 32'haa);
    idle(3);
    // rdy low for three cycles with queued results and valid inputs.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'(i), $urandom, 1'b1, 4'(4 + i), $urandom);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'(8 + i), $urandom, 1'b1, 4'(12 + i), $urandom, 1'b0);
    idle(6);
    // Wrap the ALU queue under LSB contention.
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 4'(i), $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
    idle(6);
    // Random mix including rdy stalls and occasional flushes.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom,
          $urandom_range(0, 3) != 0, 4'($urandom), $urandom,
          $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
